// File: rtl/hour_set_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hour_set_pkg
// Description : Shared state encoding and BCD mod-N helpers for time setters.
// Revision    : 1.0
// ============================================================================
package hour_set_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] HOUR_MIN = 8'h00;

    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Wraps max -> 00; callers pass HOUR_MAX, or 8'h59 for minute/second setters.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v >= max)
            r = HOUR_MIN;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = v + 8'd1;
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == HOUR_MIN)
            r = max;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = v - 8'd1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hour_set_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hour_set_ctrl_if
// Description : Load port between the hour setter (master) and hour counter.
// Revision    : 1.0
// ============================================================================
interface hour_set_ctrl_if;
    logic [7:0] cur_hour;
    logic       load;
    logic [7:0] data;
    logic       en;

    modport master (input cur_hour, output load, output data, output en);
    modport slave  (output cur_hour, input load, input data, input en);
endinterface
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync_edge
// Description : 2-flop synchronizer, debounce filter and rising-edge pulse.
// Revision    : 1.0
// ============================================================================
module btn_sync_edge #(
    parameter int DEB_CYCLES = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic btn,
    output logic      pulse
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    // A differing sample run of DEB_CYCLES flips the accepted level; any agreeing sample restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 != r_stable) begin
                if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    r_stable <= r_sync2;
                    r_pulse  <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/hour_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hour_set_ctrl
// Description : Button-driven hour edit session feeding the counter load port.
// Revision    : 1.0
// ============================================================================
module hour_set_ctrl
    import hour_set_pkg::*;
#(
    parameter int DEB_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int BLINK_HALF     = 256,
    parameter int LOAD_CYCLES    = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          btn_mode,
    input  wire logic          btn_up,
    input  wire logic          btn_down,
    hour_set_ctrl_if.master    bus,
    output logic               editing,
    output logic               blink
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int LD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    logic w_mode;
    logic w_up;
    logic w_down;

    state_t          r_state;
    logic [7:0]      r_value;
    logic            r_load;
    logic            r_en;
    logic            r_editing;
    logic            r_blink;
    logic [TO_W-1:0] r_to_cnt;
    logic [BL_W-1:0] r_blink_cnt;
    logic [LD_W-1:0] r_ld_cnt;

    btn_sync_edge #(.DEB_CYCLES(DEB_CYCLES)) u_sync_mode (
        .clk(clk), .rst_n(rst_n), .btn(btn_mode), .pulse(w_mode)
    );
    btn_sync_edge #(.DEB_CYCLES(DEB_CYCLES)) u_sync_up (
        .clk(clk), .rst_n(rst_n), .btn(btn_up), .pulse(w_up)
    );
    btn_sync_edge #(.DEB_CYCLES(DEB_CYCLES)) u_sync_down (
        .clk(clk), .rst_n(rst_n), .btn(btn_down), .pulse(w_down)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_value     <= HOUR_MIN;
            r_load      <= 1'b0;
            r_en        <= 1'b1;
            r_editing   <= 1'b0;
            r_blink     <= 1'b0;
            r_to_cnt    <= '0;
            r_blink_cnt <= '0;
            r_ld_cnt    <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_load    <= 1'b0;
                    r_en      <= 1'b1;
                    r_editing <= 1'b0;
                    r_blink   <= 1'b0;
                    if (w_mode) begin
                        r_state     <= ST_EDIT;
                        r_value     <= bcd_valid(bus.cur_hour, HOUR_MAX) ? bus.cur_hour : HOUR_MIN;
                        r_en        <= 1'b0;
                        r_editing   <= 1'b1;
                        r_to_cnt    <= '0;
                        r_blink_cnt <= '0;
                    end
                end
                ST_EDIT: begin
                    if (r_blink_cnt == BL_W'(BLINK_HALF - 1)) begin
                        r_blink_cnt <= '0;
                        r_blink     <= ~r_blink;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                    // Mode outranks Up/Down; leaving EDIT overrides the blink toggle above.
                    if (w_mode) begin
                        r_state  <= ST_COMMIT;
                        r_load   <= 1'b1;
                        r_ld_cnt <= '0;
                        r_blink  <= 1'b0;
                    end else if (w_up || w_down) begin
                        r_to_cnt <= '0;
                        if (w_up && !w_down)
                            r_value <= bcd_inc(r_value, HOUR_MAX);
                        else if (w_down && !w_up)
                            r_value <= bcd_dec(r_value, HOUR_MAX);
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= ST_RUN;
                        r_en      <= 1'b1;
                        r_editing <= 1'b0;
                        r_blink   <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (r_ld_cnt == LD_W'(LOAD_CYCLES - 1)) begin
                        r_state   <= ST_RUN;
                        r_load    <= 1'b0;
                        r_en      <= 1'b1;
                        r_editing <= 1'b0;
                    end else begin
                        r_ld_cnt <= r_ld_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.load = r_load;
    assign bus.data = r_value;
    assign bus.en   = r_en;
    assign editing  = r_editing;
    assign blink    = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_hour_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hour_set_ctrl
// Description : Randomized self-checking bench for hour_set_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_hour_set_ctrl;

    localparam int DEB     = 16;
    localparam int TIMEOUT = 1024;
    localparam int BHALF   = 256;
    localparam int LOADC   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic editing;
    logic blink;

    int tests = 0;
    int fails = 0;

    hour_set_ctrl_if bus ();

    hour_set_ctrl #(
        .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TIMEOUT), .BLINK_HALF(BHALF), .LOAD_CYCLES(LOADC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .bus(bus), .editing(editing), .blink(blink)
    );

    always #5 clk = ~clk;

    // Load-pulse recorder: one entry per completed LOAD pulse.
    int         q_len[$];
    logic [7:0] q_data[$];
    bit         q_ok[$];
    int         load_starts = 0;
    bit         in_load = 0;
    int         run_len;
    logic [7:0] run_data;
    bit         run_ok;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_load = 0;
        end else if (bus.load === 1'b1 && !in_load) begin
            in_load = 1; run_len = 1; run_data = bus.data; run_ok = (bus.en === 1'b0);
            load_starts++;
        end else if (bus.load === 1'b1) begin
            run_len++;
            if (bus.data !== run_data || bus.en !== 1'b0) run_ok = 0;
        end else if (in_load) begin
            in_load = 0;
            q_len.push_back(run_len);
            q_data.push_back(run_data);
            q_ok.push_back(run_ok && bus.en === 1'b1);
        end
    end

    // Reference model works on plain integer hours 0..23.
    function automatic logic [7:0] to_bcd(input int h);
        return 8'((h / 10) * 16 + (h % 10));
    endfunction

    function automatic int entry_hour(input logic [7:0] cur);
        int t, u;
        t = int'(cur[7:4]);
        u = int'(cur[3:0]);
        if (u <= 9 && t * 10 + u <= 23) return t * 10 + u;
        return 0;
    endfunction

    task automatic press(input logic m, input logic u, input logic d);
        btn_mode = m; btn_up = u; btn_down = d;
        repeat (24) @(posedge clk);
        #1;
        btn_mode = 0; btn_up = 0; btn_down = 0;
        repeat (24) @(posedge clk);
        #1;
    endtask

    task automatic check_edit(input string name, input int h);
        tests++;
        if (bus.data !== to_bcd(h) || editing !== 1'b1 || bus.en !== 1'b0) begin
            fails++;
            $display("FAIL %s: data=%h editing=%b en=%b, expected data=%h editing=1 en=0",
                     name, bus.data, editing, bus.en, to_bcd(h));
        end
    endtask

    task automatic check_commit(input string name, input int h);
        int n = 0;
        while (q_len.size() == 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (q_len.size() == 0) begin
            fails++;
            $display("FAIL %s: no LOAD pulse seen, expected one with data=%h", name, to_bcd(h));
        end else begin
            int len; logic [7:0] d; bit ok;
            len = q_len.pop_front(); d = q_data.pop_front(); ok = q_ok.pop_front();
            if (len != LOADC || d !== to_bcd(h) || !ok || q_len.size() != 0) begin
                fails++;
                $display("FAIL %s: load len=%0d data=%h en_ok=%0d extra=%0d, expected len=%0d data=%h en_ok=1 extra=0",
                         name, len, d, ok, q_len.size(), LOADC, to_bcd(h));
            end
        end
        tests++;
        if (editing !== 1'b0 || bus.en !== 1'b1 || bus.load !== 1'b0 || bus.data !== to_bcd(h)) begin
            fails++;
            $display("FAIL %s_after: editing=%b en=%b load=%b data=%h, expected 0 1 0 %h",
                     name, editing, bus.en, bus.load, bus.data, to_bcd(h));
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.load, bus.en, bus.data, editing, blink} !== 12'b0_1_00000000_0_0) begin
            fails++;
            $display("FAIL reset: load=%b en=%b data=%h editing=%b blink=%b, expected 0 1 00 0 0",
                     bus.load, bus.en, bus.data, editing, blink);
        end
        rst_n = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({bus.load, bus.en, bus.data, editing, blink} !== 12'b0_1_00000000_0_0) begin
                fails++;
                $display("FAIL idle[%0d]: load=%b en=%b data=%h editing=%b blink=%b, expected 0 1 00 0 0",
                         i, bus.load, bus.en, bus.data, editing, blink);
            end
        end
    endtask

    task automatic test_wrap_up();
        bus.cur_hour = 8'h22;
        press(1, 0, 0); check_edit("wrap_entry", 22);
        press(0, 1, 0); check_edit("wrap_up1", 23);
        press(0, 1, 0); check_edit("wrap_up2", 0);
        press(1, 0, 0); check_commit("wrap_commit", 0);
    endtask

    task automatic test_down();
        bus.cur_hour = 8'h10;
        press(1, 0, 0); check_edit("down_entry", 10);
        press(0, 0, 1); check_edit("down_10", 9);
        press(1, 0, 0); check_commit("down_commit", 9);
        bus.cur_hour = 8'h00;
        press(1, 0, 0); check_edit("down0_entry", 0);
        press(0, 0, 1); check_edit("down_00", 23);
        press(1, 0, 0); check_commit("down0_commit", 23);
    endtask

    // Five toggles three cycles apart, ending high; DATA moves one cycle after the pulse.
    task automatic test_bounce();
        int n;
        logic [7:0] prev;
        bus.cur_hour = 8'h07;
        press(1, 0, 0); check_edit("bounce_entry", 7);
        prev = bus.data;
        for (int i = 0; i < 5; i++) begin
            btn_up = (i % 2 == 0);
            if (i < 4) begin
                repeat (3) @(posedge clk);
                #1;
            end
        end
        n = 0;
        while (bus.data === prev && n < 60) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (n != 2 + DEB + 1) begin
            fails++;
            $display("FAIL bounce_latency: data changed after %0d cycles, expected %0d", n, 2 + DEB + 1);
        end
        repeat (10) @(posedge clk);
        #1;
        btn_up = 0;
        repeat (24) @(posedge clk);
        #1;
        check_edit("bounce_once", 8);
        press(1, 0, 0); check_commit("bounce_commit", 8);
    endtask

    task automatic test_timeout();
        int n = 0;
        int starts;
        starts = load_starts;
        bus.cur_hour = 8'h15;
        btn_mode = 1;
        while (editing !== 1'b1 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (editing !== 1'b1 || bus.data !== 8'h15) begin
            fails++;
            $display("FAIL timeout_entry: editing=%b data=%h, expected 1 15", editing, bus.data);
        end
        for (int k = 1; k <= TIMEOUT + 6; k++) begin
            logic exp_ed, exp_bl;
            @(posedge clk); #1;
            if (k == 5) btn_mode = 0;
            exp_ed = (k < TIMEOUT);
            exp_bl = exp_ed ? 1'((k / BHALF) % 2) : 1'b0;
            tests++;
            if (editing !== exp_ed || blink !== exp_bl || bus.en !== ~exp_ed || bus.load !== 1'b0) begin
                fails++;
                $display("FAIL timeout[%0d]: editing=%b blink=%b en=%b load=%b, expected %b %b %b 0",
                         k, editing, blink, bus.en, bus.load, exp_ed, exp_bl, ~exp_ed);
            end
        end
        tests++;
        if (load_starts != starts || bus.data !== 8'h15) begin
            fails++;
            $display("FAIL timeout_noload: loads=%0d data=%h, expected 0 15", load_starts - starts, bus.data);
        end
    endtask

    task automatic test_invalid_and_combos();
        bus.cur_hour = 8'h3A;
        press(1, 0, 0); check_edit("invalid_entry", 0);
        press(0, 1, 1); check_edit("up_down_same", 0);
        press(1, 1, 0); check_commit("mode_up_same", 0);
        bus.cur_hour = 8'h24;
        press(1, 0, 0); check_edit("over23_entry", 0);
        press(0, 0, 1); check_edit("over23_down", 23);
        press(1, 0, 1); check_commit("mode_down_same", 23);
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            logic [7:0] cur;
            int h, np;
            cur = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd(int'($urandom_range(0, 23)));
            bus.cur_hour = cur;
            h = entry_hour(cur);
            press(1, 0, 0); check_edit("rand_entry", h);
            np = $urandom_range(3, 6);
            for (int p = 0; p < np; p++) begin
                int r;
                r = $urandom_range(0, 3);
                case (r)
                    0, 3: begin press(0, 1, 0); h = (h + 1) % 24; end
                    1:    begin press(0, 0, 1); h = (h + 23) % 24; end
                    default: press(0, 1, 1);
                endcase
                check_edit("rand_step", h);
            end
            press(1, 0, 0); check_commit("rand_commit", h);
        end
    endtask

    task automatic test_reset_commit();
        int n = 0;
        bus.cur_hour = 8'h12;
        press(1, 0, 0); check_edit("rstc_entry", 12);
        btn_mode = 1;
        while (bus.load !== 1'b1 && n < 60) begin
            @(negedge clk); n++;
        end
        #2;
        rst_n = 0;
        #1;
        tests++;
        if (n >= 60 || {bus.load, bus.en, bus.data, editing, blink} !== 12'b0_1_00000000_0_0) begin
            fails++;
            $display("FAIL reset_mid_commit: seen=%0d load=%b en=%b data=%h editing=%b, expected 0 1 00 0",
                     n < 60, bus.load, bus.en, bus.data, editing);
        end
        btn_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (30) @(posedge clk);
        #1;
        q_len.delete(); q_data.delete(); q_ok.delete();
        tests++;
        if (bus.load !== 1'b0 || bus.en !== 1'b1 || editing !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_commit: load=%b en=%b editing=%b, expected 0 1 0",
                     bus.load, bus.en, editing);
        end
    endtask

    initial begin
        bus.cur_hour = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_wrap_up();
        test_down();
        test_bounce();
        test_timeout();
        test_invalid_and_combos();
        test_random();
        test_reset_commit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
